// File: rtl/control_puertas_param.sv
// Door controller for one elevator car.
// Opens the floor door when the car is stopped at a floor with a pending stop
// (or when the cabin open button is pressed), holds it open for a programmable
// time, closes it, and re-opens on obstruction up to a bounded number of
// retries before raising an obstruction alarm.
//
// Output timing: salida_puertas, atendido, timeout and aviso are registered
// and change together with the state they belong to. atendido and timeout are
// one-cycle pulses in the first cycle of the state that follows the event
// (first ABRIENDO cycle, first CERRANDO cycle). puertas and trabajando are
// decoded from the registered state and latched floor.
module control_puertas_param #(
   parameter int N_PISOS        = 8,
   parameter int T_MOV          = 5,
   parameter int T_ABIERTA      = 20,
   parameter int MAX_REINTENTOS = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(N_PISOS)-1:0] pisos,
   input  logic [1:0]                 estado,
   input  logic [N_PISOS-1:0]         botones,
   input  logic                       boton,
   input  logic                       boton_cerrar,
   input  logic                       sensor,
   output logic [N_PISOS-1:0]         puertas,
   output logic [1:0]                 salida_puertas,
   output logic [N_PISOS-1:0]         atendido,
   output logic                       timeout,
   output logic                       aviso,
   output logic                       trabajando
);

   localparam int PW    = $clog2(N_PISOS);
   localparam int T_MAX = (T_MOV > T_ABIERTA) ? T_MOV : T_ABIERTA;
   // A one-cycle timer still needs a one-bit counter
   localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int RW    = $clog2(MAX_REINTENTOS + 1);

   localparam logic [CW-1:0] C_MOV = CW'(T_MOV - 1);
   localparam logic [CW-1:0] C_ABI = CW'(T_ABIERTA - 1);
   localparam logic [RW-1:0] R_MAX = RW'(MAX_REINTENTOS);
   localparam logic [PW:0]   P_LIM = (PW + 1)'(N_PISOS);

   localparam logic [1:0] MOTOR_IDLE  = 2'b00;
   localparam logic [1:0] MOTOR_OPEN  = 2'b01;
   localparam logic [1:0] MOTOR_CLOSE = 2'b10;

   typedef enum logic [2:0] {
      CERRADA  = 3'd0,
      ABRIENDO = 3'd1,
      ABIERTA  = 3'd2,
      CERRANDO = 3'd3,
      AVISO    = 3'd4
   } fsm_t;

   fsm_t            fsm;
   logic [CW-1:0]   cnt;
   logic [RW-1:0]   reint;
   logic [PW-1:0]   piso_lat;

   logic            piso_ok;
   logic            pedido;
   logic            obstruido;
   logic [RW-1:0]   reint_inc;
   logic            cnt_cero;
   logic [CW-1:0]   cnt_dec;

   // Service request seen at the current floor, and shared next-value terms
   always_comb begin
      piso_ok   = ({1'b0, pisos} < P_LIM);
      pedido    = (estado == 2'b00) && piso_ok && (botones[pisos] || boton);
      obstruido = sensor || boton;
      reint_inc = reint + RW'(1);
      cnt_cero  = (cnt == '0);
      cnt_dec   = cnt - CW'(1);
   end

   // Door sequencer: state, timer, retry count, floor latch and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm            <= CERRADA;
         cnt            <= '0;
         reint          <= '0;
         piso_lat       <= '0;
         salida_puertas <= MOTOR_IDLE;
         atendido       <= '0;
         timeout        <= 1'b0;
         aviso          <= 1'b0;
      end else begin
         atendido <= '0;
         timeout  <= 1'b0;
         case (fsm)
            CERRADA: begin
               // Car out of service or moving: no door action
               if (pedido) begin
                  fsm            <= ABRIENDO;
                  cnt            <= C_MOV;
                  piso_lat       <= pisos;
                  atendido       <= N_PISOS'(1) << pisos;
                  salida_puertas <= MOTOR_OPEN;
               end
            end

            ABRIENDO: begin
               // Opening travel always runs to completion
               if (cnt_cero) begin
                  fsm            <= ABIERTA;
                  cnt            <= C_ABI;
                  salida_puertas <= MOTOR_IDLE;
               end else begin
                  cnt <= cnt_dec;
               end
            end

            ABIERTA: begin
               // Open request or obstruction restarts the hold, and beats close
               if (obstruido) begin
                  cnt <= C_ABI;
               end else if (cnt_cero) begin
                  fsm            <= CERRANDO;
                  cnt            <= C_MOV;
                  timeout        <= 1'b1;
                  salida_puertas <= MOTOR_CLOSE;
               end else if (boton_cerrar) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt_dec;
               end
            end

            CERRANDO: begin
               // Obstruction wins over end of travel in the same cycle
               if (obstruido) begin
                  reint <= reint_inc;
                  cnt   <= (reint_inc == R_MAX) ? C_ABI : C_MOV;
                  if (reint_inc == R_MAX) begin
                     fsm            <= AVISO;
                     salida_puertas <= MOTOR_IDLE;
                     aviso          <= 1'b1;
                  end else begin
                     fsm            <= ABRIENDO;
                     salida_puertas <= MOTOR_OPEN;
                  end
               end else if (cnt_cero) begin
                  fsm            <= CERRADA;
                  reint          <= '0;
                  salida_puertas <= MOTOR_IDLE;
               end else begin
                  cnt <= cnt_dec;
               end
            end

            AVISO: begin
               // Door held open until the obstruction has been clear for a full hold time
               if (sensor) begin
                  cnt <= C_ABI;
               end else if (cnt_cero) begin
                  fsm            <= CERRANDO;
                  cnt            <= C_MOV;
                  reint          <= '0;
                  aviso          <= 1'b0;
                  salida_puertas <= MOTOR_CLOSE;
               end else begin
                  cnt <= cnt_dec;
               end
            end

            default: begin
               fsm            <= CERRADA;
               cnt            <= '0;
               reint          <= '0;
               salida_puertas <= MOTOR_IDLE;
               aviso          <= 1'b0;
            end
         endcase
      end
   end

   // Door-not-closed indications decoded from the registered state
   always_comb begin
      trabajando = (fsm != CERRADA);
      puertas    = trabajando ? (N_PISOS'(1) << piso_lat) : '0;
   end

endmodule
